ml_llr_scheduler: RTL
=====================

ML_LLR_SCHEDULER -- requirements
Module: ml_llr_scheduler

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 20, metric datapath word width.
REQ-002 SHALL have parameter N_BITS, default 6, candidate index width (64 candidates).
REQ-003 SHALL have ports: i_clk  in  1  single clock; all logic on rising edge.
REQ-004 i_reset  in  1  synchronous, active-high reset.
REQ-005 i_start  in  1  one-cycle request to detect one symbol vector.
REQ-006 o_idle  out  1  high only in IDLE; i_start accepted only when high.
REQ-007 o_enable  out  1  issue strobe to metric pipeline (drives its i_enable).
REQ-008 o_cnt  out  N_BITS  candidate index issued with o_enable.
REQ-009 i_res_valid  in  1  metric result strobe from pipeline.
REQ-010 i_res_cnt  in  N_BITS  candidate index tagged on the result.
REQ-011 i_res_dist  in  DATA_WIDTH+2  unsigned distance metric of that candidate.
REQ-012 o_llr_valid  out  1  LLR output beat valid.
REQ-013 i_llr_ready  in  1  downstream accepts beat when high with o_llr_valid.
REQ-014 o_llr  out  DATA_WIDTH+3  signed LLR for bit o_llr_idx.
REQ-015 o_llr_idx  out  3  bit index 0..N_BITS-1 of current beat.
REQ-016 o_best_cnt  out  N_BITS  index of minimum-distance candidate, stable from first LLR beat to next accepted start.
REQ-017 o_done  out  1  one-cycle pulse after final LLR beat accepted.

Function
REQ-018 States SHALL be IDLE, ISSUE, DRAIN, OUTPUT; IDLE->ISSUE on i_start in IDLE; i_start in other states ignored.
REQ-019 ISSUE SHALL assert o_enable for exactly 64 consecutive cycles with o_cnt = 0,1,...,63, then enter DRAIN.
REQ-020 A 7-bit receive counter SHALL count i_res_valid beats in ISSUE and DRAIN; at 64 received, enter OUTPUT next cycle.
REQ-021 i_res_valid in IDLE or OUTPUT SHALL be ignored (no state change, no counter change).
REQ-022 On each accepted result, for each bit k: if i_res_cnt[k]=1 update min1[k], else min0[k], when i_res_dist strictly less than stored value (ties keep earlier).
REQ-023 Global minimum and o_best_cnt SHALL update on strictly smaller distance; ties keep earlier result.
REQ-024 Mins SHALL initialise to all-ones (2^(DATA_WIDTH+2)-1) on entry to ISSUE.
REQ-025 LLR[k] SHALL equal min1[k] - min0[k], zero-extended operands, full-precision signed DATA_WIDTH+3 result, no saturation.
REQ-026 OUTPUT SHALL present beats k=0..N_BITS-1 in order; beat advances only on o_llr_valid & i_llr_ready; o_llr/o_llr_idx held stable while stalled.
REQ-027 Acceptance of beat N_BITS-1 SHALL return to IDLE and pulse o_done in the same edge's following cycle.
REQ-028 i_start in the o_done cycle SHALL be accepted (o_idle high that cycle).
REQ-029 Pipeline latency (o_enable to i_res_valid) is not assumed; any latency with in-order or reordered results SHALL produce identical LLRs.

Reset
REQ-030 On i_reset at any state, including mid-ISSUE or stalled OUTPUT, next cycle SHALL be IDLE with o_idle=1, o_enable=0, o_cnt=0, o_llr_valid=0, o_llr=0, o_llr_idx=0, o_best_cnt=0, o_done=0, counters 0, mins all-ones.
REQ-031 Results arriving after reset SHALL be ignored until next ISSUE.

Structure
REQ-032 Shared package SHALL hold state encoding (IDLE=0, ISSUE=1, DRAIN=2, OUTPUT=3), N_CAND=64, metric/LLR width constants.
REQ-033 One sub-module ml_min_tracker (per-bit min0/min1 compare-update, N_BITS instances or vectorised) SHALL be used; FSM and output mux in top.

Verification
REQ-034 Dist = index+1 for index 0..63, fixed 4-cycle latency, ready=1 -> LLR[k] = 2^k (e.g. k=5: 33-1=32), o_best_cnt=0, done 64+4+1+6 cycles after start region.
REQ-035 Dist = 100 except index 42 = 5, results reversed order -> LLR[k] = -95 for bits set in 42 (1,3,5), +95 for bits 0,2,4; o_best_cnt=42.
REQ-036 All dist = all-ones -> all LLR = 0, o_best_cnt=0 (tie keeps first).
REQ-037 i_llr_ready toggled 1/0 every cycle -> six beats, each held stable during stall, idx 0..5, o_done once.
REQ-038 i_reset asserted at ISSUE cycle 30 then new start with REQ-034 stimulus -> stale in-flight results ignored, LLRs match REQ-034.
REQ-039 i_start held high continuously -> back-to-back detections, second ISSUE begins cycle after o_done; i_start during ISSUE/DRAIN/OUTPUT has no effect.

Source files
------------

// File: rtl/ml_llr_scheduler_pkg.sv
// Shared constants and FSM encoding for the max-log LLR scheduler.
package ml_llr_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    DRAIN  = 2'd2,
    OUTPUT = 2'd3
  } state_e;

  localparam int N_CAND         = 64;
  localparam int DEF_N_BITS     = $clog2(N_CAND);
  localparam int DEF_DATA_WIDTH = 20;

  // Distance metrics carry two guard bits; the LLR adds one more for the sign.
  function automatic int metric_width(input int data_width);
    return data_width + 2;
  endfunction

  function automatic int llr_width(input int data_width);
    return data_width + 3;
  endfunction

endpackage

// File: rtl/ml_llr_scheduler_if.sv
// Result bus from the metric pipeline into the min tracker.
interface ml_llr_scheduler_if #(
  parameter int DATA_WIDTH = ml_llr_scheduler_pkg::DEF_DATA_WIDTH,
  parameter int N_BITS     = ml_llr_scheduler_pkg::DEF_N_BITS
);
  // res_valid is a one-cycle strobe with no backpressure: every strobed beat is consumed.
  logic                  res_valid;
  logic [N_BITS-1:0]     res_cnt;
  logic [DATA_WIDTH+1:0] res_dist;

  modport master (output res_valid, res_cnt, res_dist);
  modport slave  (input  res_valid, res_cnt, res_dist);
endinterface

// File: rtl/ml_llr_scheduler_min_tracker.sv
// Per-bit min0/min1 trackers plus the global minimum and its candidate index.
module ml_min_tracker
  import ml_llr_scheduler_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int N_BITS     = DEF_N_BITS
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 i_clear,
  ml_llr_scheduler_if.slave                    res,
  output logic [N_BITS-1:0][DATA_WIDTH+1:0]    o_min0,
  output logic [N_BITS-1:0][DATA_WIDTH+1:0]    o_min1,
  output logic [N_BITS-1:0]                    o_best_cnt
);
  localparam int MW = DATA_WIDTH + 2;

  logic [N_BITS-1:0][MW-1:0] min0_q, min0_d, min1_q, min1_d;
  logic [MW-1:0]             gmin_q, gmin_d;
  logic [N_BITS-1:0]         best_q, best_d;

  // Strict less-than everywhere so equal metrics keep the earliest arrival.
  always_comb begin
    min0_d = min0_q;
    min1_d = min1_q;
    gmin_d = gmin_q;
    best_d = best_q;
    if (i_clear) begin
      min0_d = '1;
      min1_d = '1;
      gmin_d = '1;
      best_d = '0;
    end else if (res.res_valid) begin
      for (int k = 0; k < N_BITS; k++) begin
        if (res.res_cnt[k]) begin
          if (res.res_dist < min1_q[k]) min1_d[k] = res.res_dist;
        end else begin
          if (res.res_dist < min0_q[k]) min0_d[k] = res.res_dist;
        end
      end
      if (res.res_dist < gmin_q) begin
        gmin_d = res.res_dist;
        best_d = res.res_cnt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      min0_q <= '1;
      min1_q <= '1;
      gmin_q <= '1;
      best_q <= '0;
    end else begin
      min0_q <= min0_d;
      min1_q <= min1_d;
      gmin_q <= gmin_d;
      best_q <= best_d;
    end
  end

  assign o_min0     = min0_q;
  assign o_min1     = min1_q;
  assign o_best_cnt = best_q;

endmodule

// File: rtl/ml_llr_scheduler.sv
// Issues all candidates to the metric pipeline, collects results, then streams per-bit LLRs.
module ml_llr_scheduler
  import ml_llr_scheduler_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int N_BITS     = DEF_N_BITS
) (
  input  logic                         i_clk,
  input  logic                         i_reset,
  input  logic                         i_start,
  output logic                         o_idle,
  output logic                         o_enable,
  output logic [N_BITS-1:0]            o_cnt,
  input  logic                         i_res_valid,
  input  logic [N_BITS-1:0]            i_res_cnt,
  input  logic [DATA_WIDTH+1:0]        i_res_dist,
  output logic                         o_llr_valid,
  input  logic                         i_llr_ready,
  output logic signed [DATA_WIDTH+2:0] o_llr,
  output logic [2:0]                   o_llr_idx,
  output logic [N_BITS-1:0]            o_best_cnt,
  output logic                         o_done,
  output state_e                       o_dbg_state
);
  localparam int                RW       = N_BITS + 1;
  localparam int                LW       = DATA_WIDTH + 3;
  localparam logic [RW-1:0]     RX_FULL  = RW'(1 << N_BITS);
  localparam logic [N_BITS-1:0] LAST_CNT = '1;
  localparam logic [2:0]        LAST_IDX = 3'(N_BITS - 1);

  state_e            state_q, state_d;
  logic [N_BITS-1:0] cnt_q, cnt_d;
  logic [RW-1:0]     rx_q, rx_d;
  logic [2:0]        idx_q, idx_d;
  logic              done_q, done_d;
  logic              clear, accept;

  logic [N_BITS-1:0][DATA_WIDTH+1:0] min0, min1;
  logic signed [LW-1:0]              llr_sel;

  ml_llr_scheduler_if #(.DATA_WIDTH(DATA_WIDTH), .N_BITS(N_BITS)) res_bus ();

  assign res_bus.res_valid = accept;
  assign res_bus.res_cnt   = i_res_cnt;
  assign res_bus.res_dist  = i_res_dist;

  ml_min_tracker #(.DATA_WIDTH(DATA_WIDTH), .N_BITS(N_BITS)) u_min_tracker (
    .clk        (i_clk),
    .rst        (i_reset),
    .i_clear    (clear),
    .res        (res_bus.slave),
    .o_min0     (min0),
    .o_min1     (min1),
    .o_best_cnt (o_best_cnt)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rx_d    = rx_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    clear   = 1'b0;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_start) begin
          state_d = ISSUE;
          cnt_d   = '0;
          rx_d    = '0;
          clear   = 1'b1;
        end
      end
      ISSUE: begin
        cnt_d  = cnt_q + N_BITS'(1);
        accept = i_res_valid;
        if (cnt_q == LAST_CNT) state_d = DRAIN;
      end
      DRAIN: accept = i_res_valid;
      OUTPUT: begin
        // A beat transfers on o_llr_valid & i_llr_ready; otherwise idx and data hold.
        if (i_llr_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = IDLE;
            idx_d   = '0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // A zero-latency final result can complete collection while still issuing.
    if (accept) begin
      rx_d = rx_q + RW'(1);
      if (rx_d == RX_FULL) state_d = OUTPUT;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rx_q    <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rx_q    <= rx_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    llr_sel = '0;
    for (int k = 0; k < N_BITS; k++) begin
      if (idx_q == 3'(k)) llr_sel = $signed({1'b0, min1[k]}) - $signed({1'b0, min0[k]});
    end
  end

  assign o_idle      = (state_q == IDLE);
  assign o_enable    = (state_q == ISSUE);
  assign o_cnt       = cnt_q;
  assign o_llr_valid = (state_q == OUTPUT);
  assign o_llr       = o_llr_valid ? llr_sel : '0;
  assign o_llr_idx   = idx_q;
  assign o_done      = done_q;
  assign o_dbg_state = state_q;

endmodule
